// File: rtl/serial_config_shifter.sv
// Shifts thirteen configuration bytes out to the ASIC config chain (sck/sda/scapt)
// and re-sends a full frame whenever the register bank differs from the last frame sent.
module serial_config_shifter #(
  parameter int CLKDIV     = 4,
  parameter int RST_CYCLES = 16
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [7:0] myReg1,
  input  logic [7:0] myReg2,
  input  logic [7:0] myReg3,
  input  logic [7:0] myReg4,
  input  logic [7:0] myReg5,
  input  logic [7:0] myReg6,
  input  logic [7:0] myReg7,
  input  logic [7:0] myReg8,
  input  logic [7:0] myReg9,
  input  logic [7:0] myReg10,
  input  logic [7:0] myReg11,
  input  logic [7:0] myReg12,
  input  logic [7:0] myReg13,
  output logic       sck,
  output logic       sda,
  output logic       scapt,
  output logic       reset
);

  localparam int FRAME_BITS = 104;
  localparam int CNT_MAX    = (2 * CLKDIV > RST_CYCLES) ? 2 * CLKDIV : RST_CYCLES;
  localparam int CW         = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] CAPT_LAST = CW'(2 * CLKDIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    RESET_HOLD,
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    CAPTURE
  } stateType;

  logic [7:0]            regBytes [13];
  logic [FRAME_BITS-1:0] frameIn;

  always_comb begin
    regBytes[0]  = myReg1;
    regBytes[1]  = myReg2;
    regBytes[2]  = myReg3;
    regBytes[3]  = myReg4;
    regBytes[4]  = myReg5;
    regBytes[5]  = myReg6;
    regBytes[6]  = myReg7;
    regBytes[7]  = myReg8;
    regBytes[8]  = myReg9;
    regBytes[9]  = myReg10;
    regBytes[10] = myReg11;
    regBytes[11] = myReg12;
    regBytes[12] = myReg13;
  end

  // myReg13 lands in the top byte so it is shifted out first.
  genvar gi;
  generate
    for (gi = 0; gi < 13; gi++) begin : g_pack
      assign frameIn[gi*8 +: 8] = regBytes[gi];
    end
  endgenerate

  stateType              stateReg, stateNext;
  logic [CW-1:0]         cntReg, cntNext;
  logic [6:0]            bitCntReg, bitCntNext;
  logic [FRAME_BITS-2:0] restReg, restNext;
  logic [FRAME_BITS-1:0] snapshotReg, snapshotNext;
  logic                  sckReg, sckNext;
  logic                  sdaReg, sdaNext;
  logic                  scaptReg, scaptNext;
  logic                  resetReg, resetNext;

  // sdaReg holds the bit currently on the wire; restReg holds the bits still to follow.
  always_comb begin
    stateNext    = stateReg;
    cntNext      = cntReg;
    bitCntNext   = bitCntReg;
    restNext     = restReg;
    snapshotNext = snapshotReg;
    sckNext      = sckReg;
    sdaNext      = sdaReg;
    scaptNext    = scaptReg;
    resetNext    = resetReg;
    case (stateReg)
      RESET_HOLD: begin
        if (cntReg == HOLD_LAST) begin
          resetNext = 1'b0;
          cntNext   = '0;
          stateNext = LOAD;
        end else begin
          cntNext = cntReg + CW'(1);
        end
      end
      IDLE: begin
        if (frameIn != snapshotReg) stateNext = LOAD;
      end
      LOAD: begin
        snapshotNext = frameIn;
        sdaNext      = frameIn[FRAME_BITS-1];
        restNext     = frameIn[FRAME_BITS-2:0];
        bitCntNext   = 7'(FRAME_BITS - 1);
        cntNext      = '0;
        sckNext      = 1'b0;
        stateNext    = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (cntReg == HALF_LAST) begin
          cntNext   = '0;
          sckNext   = 1'b1;
          stateNext = SHIFT_HI;
        end else begin
          cntNext = cntReg + CW'(1);
        end
      end
      SHIFT_HI: begin
        if (cntReg == HALF_LAST) begin
          cntNext = '0;
          sckNext = 1'b0;
          if (bitCntReg == 7'd0) begin
            sdaNext   = 1'b0;
            scaptNext = 1'b1;
            stateNext = CAPTURE;
          end else begin
            bitCntNext = bitCntReg - 7'd1;
            sdaNext    = restReg[FRAME_BITS-2];
            restNext   = {restReg[FRAME_BITS-3:0], 1'b0};
            stateNext  = SHIFT_LO;
          end
        end else begin
          cntNext = cntReg + CW'(1);
        end
      end
      CAPTURE: begin
        if (cntReg == CAPT_LAST) begin
          cntNext   = '0;
          scaptNext = 1'b0;
          stateNext = IDLE;
        end else begin
          cntNext = cntReg + CW'(1);
        end
      end
      default: stateNext = RESET_HOLD;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      stateReg    <= RESET_HOLD;
      cntReg      <= '0;
      bitCntReg   <= '0;
      restReg     <= '0;
      snapshotReg <= '0;
      sckReg      <= 1'b0;
      sdaReg      <= 1'b0;
      scaptReg    <= 1'b0;
      resetReg    <= 1'b1;
    end else begin
      stateReg    <= stateNext;
      cntReg      <= cntNext;
      bitCntReg   <= bitCntNext;
      restReg     <= restNext;
      snapshotReg <= snapshotNext;
      sckReg      <= sckNext;
      sdaReg      <= sdaNext;
      scaptReg    <= scaptNext;
      resetReg    <= resetNext;
    end
  end

  assign sck   = sckReg;
  assign sda   = sdaReg;
  assign scapt = scaptReg;
  assign reset = resetReg;

endmodule

// File: tb/tb_serial_config_shifter.sv
// Bench for serial_config_shifter: two instances (CLKDIV=4 and CLKDIV=1) checked every cycle
// against a timeline model of the frame, plus literal checks on the first frames.
module tb_serial_config_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] regs [1:13];
  logic       sck0, sda0, scapt0, reset0;
  logic       sck1, sda1, scapt1, reset1;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_config_shifter #(.CLKDIV(4), .RST_CYCLES(16)) dut (
    .sysclk(clk), .rst(rst),
    .myReg1(regs[1]), .myReg2(regs[2]), .myReg3(regs[3]), .myReg4(regs[4]),
    .myReg5(regs[5]), .myReg6(regs[6]), .myReg7(regs[7]), .myReg8(regs[8]),
    .myReg9(regs[9]), .myReg10(regs[10]), .myReg11(regs[11]), .myReg12(regs[12]),
    .myReg13(regs[13]),
    .sck(sck0), .sda(sda0), .scapt(scapt0), .reset(reset0)
  );

  serial_config_shifter #(.CLKDIV(1), .RST_CYCLES(3)) dutFast (
    .sysclk(clk), .rst(rst),
    .myReg1(regs[1]), .myReg2(regs[2]), .myReg3(regs[3]), .myReg4(regs[4]),
    .myReg5(regs[5]), .myReg6(regs[6]), .myReg7(regs[7]), .myReg8(regs[8]),
    .myReg9(regs[9]), .myReg10(regs[10]), .myReg11(regs[11]), .myReg12(regs[12]),
    .myReg13(regs[13]),
    .sck(sck1), .sda(sda1), .scapt(scapt1), .reset(reset1)
  );

  function automatic logic [103:0] curFrame();
    logic [103:0] f;
    for (int j = 1; j <= 13; j++) f[j*8-1 -: 8] = regs[j];
    return f;
  endfunction

  // Timeline model: a frame is a run of 210*C cycles starting the cycle after LOAD.
  localparam int M_HOLD = 0, M_LOAD = 1, M_FRAME = 2, M_IDLE = 3;
  int           mMode [2] = '{M_HOLD, M_HOLD};
  int           mCnt  [2] = '{0, 0};
  logic [103:0] mData [2];
  logic [103:0] mSnap [2];

  always @(negedge clk) begin
    int   c, r, idx;
    logic eSck, eSda, eScapt, eReset;
    logic [3:0] got, want;
    for (int i = 0; i < 2; i++) begin
      c = (i == 0) ? 4 : 1;
      r = (i == 0) ? 16 : 3;
      if (!rst) begin
        mMode[i] = M_HOLD;
        mCnt[i]  = 0;
        mSnap[i] = '0;
      end
      eReset = (mMode[i] == M_HOLD);
      eSck = 1'b0; eSda = 1'b0; eScapt = 1'b0;
      if (mMode[i] == M_FRAME) begin
        idx = mCnt[i] / (2 * c);
        if (idx < 104) begin
          eSck = (mCnt[i] % (2 * c)) >= c;
          eSda = mData[i][103 - idx];
        end else begin
          eScapt = 1'b1;
        end
      end
      want = {eReset, eScapt, eSck, eSda};
      got  = (i == 0) ? {reset0, scapt0, sck0, sda0} : {reset1, scapt1, sck1, sda1};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL model_cdiv%0d cyc=%0d reset/scapt/sck/sda got %b required %b", c, cyc, got, want);
      end
      if (rst) begin
        case (mMode[i])
          M_HOLD: begin
            mCnt[i]++;
            if (mCnt[i] == r) begin mMode[i] = M_LOAD; mCnt[i] = 0; end
          end
          M_LOAD: begin
            mData[i] = curFrame();
            mSnap[i] = mData[i];
            mMode[i] = M_FRAME;
            mCnt[i]  = 0;
          end
          M_FRAME: begin
            mCnt[i]++;
            if (mCnt[i] == 210 * c) mMode[i] = M_IDLE;
          end
          default: if (curFrame() != mSnap[i]) mMode[i] = M_LOAD;
        endcase
      end
    end
  end

  // Recorder: bits seen at each sck rise of the CLKDIV=4 instance, one entry per scapt pulse.
  logic         prevSck = 0, prevScapt = 0, prevSck1 = 0, prevScapt1 = 0, inFrame1 = 0;
  logic [103:0] bits;
  logic [103:0] frameQ [$];
  int nBits = 0, lastNbits = 0, firstSckCyc = 0, scaptRiseCyc = 0;
  int scaptRun = 0, scaptLen = 0, resetHighCnt = 0, sckEdges = 0;
  int firstSck1 = 0, frameLen1 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      nBits = 0; prevSck = 0; prevScapt = 0; prevSck1 = 0; prevScapt1 = 0;
      inFrame1 = 0; resetHighCnt = 0;
    end else begin
      if (reset0) resetHighCnt++;
      if (sck0 && !prevSck) begin
        if (nBits == 0) firstSckCyc = cyc;
        bits = {bits[102:0], sda0};
        nBits++;
        sckEdges++;
      end
      if (scapt0 && !prevScapt) begin
        frameQ.push_back(bits);
        lastNbits = nBits;
        nBits = 0;
        scaptRiseCyc = cyc;
        scaptRun = 0;
      end
      if (scapt0) scaptRun++;
      if (!scapt0 && prevScapt) scaptLen = scaptRun;
      if (sck1 && !prevSck1 && !inFrame1) begin firstSck1 = cyc; inFrame1 = 1; end
      if (!scapt1 && prevScapt1) begin frameLen1 = cyc - (firstSck1 - 1); inFrame1 = 0; end
      prevSck = sck0; prevScapt = scapt0; prevSck1 = sck1; prevScapt1 = scapt1;
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0d required %0d", name, got, want);
    end else $display("[TB] ok %s = %0d", name, got);
  endtask

  task automatic checkFrame(input string name, input logic [103:0] got, input logic [103:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h required %h", name, got, want);
    end else $display("[TB] ok %s = %h", name, got);
  endtask

  task automatic waitFrames(input int target, input int limit);
    int t = 0;
    while (frameQ.size() < target && t < limit) begin @(posedge clk); t++; end
    tests++;
    if (frameQ.size() < target) begin
      fails++;
      $display("FAIL frame_wait got %0d frames required %0d", frameQ.size(), target);
    end
    repeat (12) @(posedge clk);
    #2;
  endtask

  task automatic waitBits(input int n);
    int t = 0;
    while (nBits < n && t < 3000) begin @(negedge clk); t++; end
    tests++;
    if (nBits < n) begin
      fails++;
      $display("FAIL bit_wait got %0d bits required %0d", nBits, n);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    int f0, e0, x;
    for (int j = 1; j <= 13; j++) regs[j] = (j == 13) ? 8'h10 : 8'(j - 1);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", sck0, 0);
    check("rst_sda", sda0, 0);
    check("rst_scapt", scapt0, 0);
    check("rst_reset", reset0, 1);
    #1 rst = 1'b1;

    // First frame after reset release.
    waitFrames(1, 3000);
    checkFrame("frame1_bits", frameQ[0], 104'h100B0A09080706050403020100);
    check("frame1_nbits", lastNbits, 104);
    check("reset_hold_cycles", resetHighCnt, 16);
    check("scapt_len", scaptLen, 8);
    check("frame1_shift_len", scaptRiseCyc - firstSckCyc + 4, 832);
    check("fast_frame_len", frameLen1, 210);

    // Steady inputs: the bus stays quiet.
    e0 = sckEdges; f0 = frameQ.size();
    repeat (2000) @(posedge clk);
    #2;
    check("steady_sck_edges", sckEdges - e0, 0);
    check("steady_frames", frameQ.size(), f0);
    check("steady_sck", sck0, 0);
    check("steady_scapt", scapt0, 0);

    // Change in IDLE: first sck high lands 2 + CLKDIV cycles after the mismatch cycle.
    f0 = frameQ.size();
    regs[1] = 8'h01;
    x = cyc;
    waitFrames(f0 + 1, 3000);
    check("change_latency", firstSckCyc - x, 6);
    check("change_last_byte", frameQ[f0][7:0], 8'h01);
    repeat (1000) @(posedge clk);
    #2;
    check("change_single_pulse", frameQ.size(), f0 + 1);

    // Change myReg13 during bit 50 of a frame.
    f0 = frameQ.size();
    regs[2] = 8'h22;
    waitBits(50);
    regs[13] = 8'hFF;
    waitFrames(f0 + 2, 4000);
    check("midframe_first_byte", frameQ[f0][103:96], 8'h10);
    check("next_first_byte", frameQ[f0 + 1][103:96], 8'hFF);
    repeat (1000) @(posedge clk);
    #2;
    check("midframe_two_pulses", frameQ.size(), f0 + 2);

    // Reset during bit 30, while sck is high and sda carries myReg10[2]=1.
    regs[10] = 8'hFF;
    waitBits(30);
    check("pre_reset_sck", sck0, 1);
    check("pre_reset_sda", sda0, 1);
    rst = 1'b0;
    #1;
    check("async_sck", sck0, 0);
    check("async_sda", sda0, 0);
    check("async_scapt", scapt0, 0);
    check("async_reset", reset0, 1);
    check("async_reset_fast", reset1, 1);
    f0 = frameQ.size();
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    waitFrames(f0 + 1, 3000);
    check("post_reset_nbits", lastNbits, 104);
    checkFrame("post_reset_frame", frameQ[f0], curFrame());

    // Random register traffic at random times; the per-cycle model checks everything.
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(0, 1200)) @(posedge clk);
      #2;
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        regs[$urandom_range(1, 13)] = 8'($urandom);
    end
    repeat (2200) @(posedge clk);
    #2;
    checkFrame("random_final_frame", frameQ[frameQ.size() - 1], curFrame());
    check("random_final_sck", sck0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, got time %0t", $time);
    $fatal(1);
  end

endmodule
